// File: rtl/lfsr_seq_checker_pkg.sv
// Shared constants, state encoding and feedback function for the 10-bit XNOR LFSR checker.
package lfsr_pkg;

  localparam int unsigned LFSR_W = 10;
  localparam int unsigned TAP_A  = 0;
  localparam int unsigned TAP_B  = 3;

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } chk_state_t;

  function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
    return ~(s[TAP_A] ^ s[TAP_B]);
  endfunction

endpackage

// File: rtl/lfsr_seq_checker_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk) begin
    if (clr_i) begin
      q_q <= '0;
    end else if (inc_i && (q_q != '1)) begin
      q_q <= q_q + 1'b1;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/lfsr_seq_checker.sv
// Self-synchronising checker for the serial output of a 10-bit XNOR LFSR.
module lfsr_seq_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned LOCK_MATCHES  = 16,
  parameter int unsigned UNLOCK_MISSES = 4,
  parameter int unsigned ERR_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic              locked,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_count,
  output logic              lockup,
  output logic [LFSR_W-1:0] history
);

  localparam int unsigned RUN_W  = $clog2(LOCK_MATCHES + 1);
  localparam int unsigned MISS_W = $clog2(UNLOCK_MISSES + 1);

  chk_state_t        state_q, state_d;
  logic [LFSR_W-1:0] hist_q, hist_d;
  logic [3:0]        fill_q, fill_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic              locked_q, lockup_q, err_pulse_q;
  logic              expected, mism, err_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HUNT;
      hist_q      <= '0;
      fill_q      <= '0;
      run_q       <= '0;
      miss_q      <= '0;
      locked_q    <= 1'b0;
      lockup_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      run_q       <= run_d;
      miss_q      <= miss_d;
      locked_q    <= (state_d == LOCKED);
      lockup_q    <= (state_d != HUNT) && (hist_d == '1);
      err_pulse_q <= err_inc;
    end
  end

  always_comb begin
    state_d  = state_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    run_d    = run_q;
    miss_d   = miss_q;
    err_inc  = 1'b0;
    expected = lfsr_fb(hist_q);
    mism     = (in_bit != expected);
    if (in_valid) begin
      case (state_q)
        HUNT: begin
          hist_d = {in_bit, hist_q[LFSR_W-1:1]};
          fill_d = fill_q + 1'b1;
          if (fill_q == 4'(LFSR_W - 1)) begin
            state_d = VERIFY;
            run_d   = '0;
          end
        end
        VERIFY: begin
          hist_d = {in_bit, hist_q[LFSR_W-1:1]};
          if (mism) begin
            run_d = '0;
          end else if (run_q != RUN_W'(LOCK_MATCHES)) begin
            run_d = run_q + 1'b1;
          end
          // run saturates at the threshold so an all-ones history just keeps retrying
          if (!mism && (run_d == RUN_W'(LOCK_MATCHES)) && (hist_d != '1)) begin
            state_d = LOCKED;
            miss_d  = '0;
          end
        end
        LOCKED: begin
          // flywheel: the prediction, not the received bit, feeds the history
          hist_d = {expected, hist_q[LFSR_W-1:1]};
          if (mism) begin
            err_inc = 1'b1;
            miss_d  = miss_q + 1'b1;
            if (miss_d == MISS_W'(UNLOCK_MISSES)) begin
              state_d = HUNT;
              fill_d  = '0;
              miss_d  = '0;
            end
          end else begin
            miss_d = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .clr_i (reset),
    .inc_i (err_inc),
    .q_o   (err_count)
  );

  assign locked    = locked_q;
  assign lockup    = lockup_q;
  assign err_pulse = err_pulse_q;
  assign history   = hist_q;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Directed scoreboard bench for lfsr_seq_checker driven from a behavioural XNOR LFSR.
module tb_lfsr_seq_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        locked, err_pulse, lockup;
  logic [15:0] err_count;
  logic [9:0]  history;

  lfsr_seq_checker #(
    .LOCK_MATCHES  (16),
    .UNLOCK_MISSES (4),
    .ERR_W         (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .lockup    (lockup),
    .history   (history)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ck_lock;
    logic        lock;
    logic        ck_pulse;
    logic        pulse;
    logic        ck_cnt;
    logic [15:0] cnt;
    logic        ck_lkp;
    logic        lkp;
    logic        ck_hist;
    logic [9:0]  hist;
  } exp_t;

  exp_t       sb[$];
  logic [9:0] st[$];
  logic [9:0] g;
  int         tests = 0;
  int         fails = 0;

  function automatic exp_t ex(input int lk, input int pu, input int cn, input int lu);
    exp_t e;
    e = '0;
    if (lk >= 0) begin e.ck_lock  = 1'b1; e.lock  = lk[0]; end
    if (pu >= 0) begin e.ck_pulse = 1'b1; e.pulse = pu[0]; end
    if (cn >= 0) begin e.ck_cnt   = 1'b1; e.cnt   = cn[15:0]; end
    if (lu >= 0) begin e.ck_lkp   = 1'b1; e.lkp   = lu[0]; end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic v, input logic b, input exp_t e, input string tag);
    exp_t x;
    in_valid = v;
    in_bit   = b;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    if (x.ck_lock)  chk({tag, ".locked"},    32'(locked),    32'(x.lock));
    if (x.ck_pulse) chk({tag, ".err_pulse"}, 32'(err_pulse), 32'(x.pulse));
    if (x.ck_cnt)   chk({tag, ".err_count"}, 32'(err_count), 32'(x.cnt));
    if (x.ck_lkp)   chk({tag, ".lockup"},    32'(lockup),    32'(x.lkp));
    if (x.ck_hist)  chk({tag, ".history"},   32'(history),   32'(x.hist));
  endtask

  // history should equal the generator state ten bits back once ten bits are in
  function automatic exp_t with_hist(input exp_t e);
    exp_t r;
    r = e;
    if (st.size() >= 10) begin
      r.ck_hist = 1'b1;
      r.hist    = st[st.size() - 10];
    end
    return r;
  endfunction

  task automatic gen(input logic inv, input exp_t e, input string tag);
    logic b;
    st.push_back(g);
    b = g[0] ^ inv;
    g = {~(g[0] ^ g[3]), g[9:1]};
    step(1'b1, b, with_hist(e), tag);
  endtask

  task automatic idle(input exp_t e, input string tag);
    step(1'b0, 1'($urandom_range(1)), with_hist(e), tag);
  endtask

  task automatic do_reset(input string tag, input logic [9:0] seed);
    exp_t e;
    e = ex(0, 0, 0, 0);
    e.ck_hist = 1'b1;
    e.hist    = '0;
    reset = 1'b1;
    step(1'b1, 1'b1, e, tag);
    reset = 1'b0;
    st.delete();
    g = seed;
  endtask

  task automatic lock_up(input int cnt, input string tag);
    for (int i = 1; i <= 26; i++) gen(1'b0, ex(int'(i == 26), 0, cnt, 0), tag);
  endtask

  initial begin
    // 1: seed 0, continuous stream
    do_reset("t1_reset", 10'h000);
    lock_up(0, "t1_lock");
    for (int i = 0; i < 1023; i++) gen(1'b0, ex(1, 0, 0, 0), "t1_run");

    // 2: single inverted bit while locked
    do_reset("t2_reset", 10'h2A5);
    lock_up(0, "t2_lock");
    for (int i = 0; i < 5; i++) gen(1'b0, ex(1, 0, 0, 0), "t2_pre");
    gen(1'b1, ex(1, 1, 1, 0), "t2_err");
    for (int i = 0; i < 20; i++) gen(1'b0, ex(1, 0, 1, 0), "t2_post");

    // 3: four consecutive inverted bits drop lock, clean stream relocks
    do_reset("t3_reset", 10'h1C3);
    lock_up(0, "t3_lock");
    for (int i = 1; i <= 3; i++) gen(1'b1, ex(1, 1, i, 0), "t3_miss");
    gen(1'b1, ex(0, 1, 4, 0), "t3_unlock");
    lock_up(4, "t3_relock");

    // 4: in_bit stuck at 1
    do_reset("t4_reset", 10'h000);
    for (int i = 1; i <= 40; i++) begin
      exp_t e;
      e = ex(0, 0, 0, int'(i >= 10));
      if (i >= 10) begin e.ck_hist = 1'b1; e.hist = 10'h3FF; end
      step(1'b1, 1'b1, e, "t4_stuck");
    end

    // 5: in_valid toggling
    do_reset("t5_reset", 10'b0100011100);
    for (int n = 1; n <= 200; n++) begin
      gen(1'b0, ex(int'(n >= 26), 0, 0, 0), "t5_valid");
      idle(ex(int'(n >= 26), 0, 0, 0), "t5_idle");
    end

    // 6: reset while locked with errors logged
    do_reset("t6_reset", 10'h155);
    lock_up(0, "t6_lock");
    for (int k = 1; k <= 3; k++) begin
      gen(1'b1, ex(1, 1, k, 0), "t6_err");
      gen(1'b0, ex(1, 0, k, 0), "t6_gap");
      gen(1'b0, ex(1, 0, k, 0), "t6_gap");
    end
    do_reset("t6_rst_locked", 10'h0F0);
    lock_up(0, "t6_hunt");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
